piezo_sched: RTL and testbench
==============================

PIEZO_SCHED -- requirements
Module: piezo_sched

Interface
REQ-001 SHALL provide parameters:
- TICK_DIV, 200000: clk cycles per tick.
- KEY_TICKS, 2: key-beep duration in ticks.
- TIMER_TICKS, 40: timer-expiry duration in ticks.
- ALARM_MAX, 300: alarm auto-timeout in ticks.
- GAP_TICKS, 1: silent ticks between playbacks.
REQ-002 SHALL provide ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_req  in  1  one-cycle request, key beep.
- timer_req  in  1  one-cycle request, timer expiry.
- alarm_req  in  1  one-cycle request, alarm.
- stop  in  1  one-cycle cancel of playback and all pending requests.
- piezo_en  out  1  enable to the piezo tone generator.
- src  out  2  active source: 00 none, 01 key, 10 timer, 11 alarm.
- busy  out  1  high in PLAY or GAP.
- done  out  1  one-cycle pulse on natural expiry only.
- pending  out  3  latched requests {alarm,timer,key}.

Function
REQ-003 SHALL set pending bit on a cycle its req is high; bit stays set until granted or stop.
REQ-004 SHALL implement states IDLE, PLAY, GAP; all outputs registered.
REQ-005 IDLE with any pending bit: grant highest priority (alarm > timer > key), clear that bit, load duration, enter PLAY; piezo_en=1 and src valid from the next cycle.
REQ-006 IDLE with no pending: piezo_en=0, src=00, busy=0.
REQ-007 Prescaler SHALL count 0..TICK_DIV-1 and restart at 0 on every PLAY or GAP entry, so PLAY lasts exactly duration*TICK_DIV cycles.
REQ-008 Duration SHALL be KEY_TICKS, TIMER_TICKS or ALARM_MAX by source; tick counter 9 bits minimum, no wrap within any duration.
REQ-009 On last cycle of duration: done pulses 1 cycle, state -> GAP, piezo_en=0 and src=00 next cycle.
REQ-010 In PLAY, a pending bit of strictly higher priority than src SHALL preempt: current source dropped (not re-queued), no done, -> GAP next cycle.
REQ-011 Equal/lower-priority requests during PLAY SHALL only latch pending; a same-source re-request replays after GAP.
REQ-012 GAP SHALL hold piezo_en=0, busy=1 for GAP_TICKS*TICK_DIV cycles, then -> IDLE.
REQ-013 stop in any state: next cycle state=IDLE, pending=000, piezo_en=0, src=00, no done.
REQ-014 stop and any req in the same cycle: stop wins, req discarded.
REQ-015 Preemption and natural expiry in the same cycle: expiry wins (done pulses), higher request served after GAP.

Reset
REQ-016 rst high SHALL immediately force state=IDLE, pending=000, prescaler=0, tick counter=0, piezo_en=0, src=00, busy=0, done=0, independent of clk.
REQ-017 Deassertion SHALL resume from IDLE on the next rising edge; reset mid-PLAY abandons playback with no done.

Verification (TICK_DIV=4, KEY_TICKS=2, TIMER_TICKS=3, ALARM_MAX=5, GAP_TICKS=1)
REQ-018 key_req at cycle 0 -> src=01, piezo_en=1 cycles 2..9, done at cycle 9, GAP cycles 10..13, busy=0 from 14.
REQ-019 timer_req then alarm_req 3 cycles into PLAY -> timer preempted, no done, GAP 4 cycles, then src=11 for 20 cycles, done at end.
REQ-020 key_req, timer_req, alarm_req same cycle in IDLE -> served alarm, timer, key in order, each separated by 4-cycle GAP, three done pulses.
REQ-021 stop mid-PLAY with pending=010 -> next cycle piezo_en=0, pending=000, busy=0, no done; stop+key_req same cycle leaves pending=000.
REQ-022 rst asserted mid-PLAY between clock edges -> piezo_en, src, busy drop at once; after release, key_req plays normally.
REQ-023 alarm_req on exact expiry cycle of timer playback -> done pulses, GAP, then alarm plays.

Source files
------------

// File: rtl/piezo_if.sv
// Request/status bundle between a sound-event source and piezo_sched.
// master drives requests and stop; slave returns tone enable and status.
interface piezo_if;
  logic       key_req;
  logic       timer_req;
  logic       alarm_req;
  logic       stop;
  logic       piezo_en;
  logic [1:0] src;
  logic       busy;
  logic       done;
  logic [2:0] pending;

  modport master (
    output key_req, timer_req, alarm_req, stop,
    input  piezo_en, src, busy, done, pending
  );

  modport slave (
    input  key_req, timer_req, alarm_req, stop,
    output piezo_en, src, busy, done, pending
  );
endinterface

// File: rtl/piezo_sched.sv
// Piezo playback scheduler: latches key/timer/alarm requests, plays the
// highest-priority one for a tick-based duration, then a silent gap.
// Ports: clk, rst (async, active high), bus (piezo_if.slave):
//   key_req/timer_req/alarm_req/stop in; piezo_en/src/busy/done/pending out.
module piezo_sched #(
  parameter int TICK_DIV    = 200000,
  parameter int KEY_TICKS   = 2,
  parameter int TIMER_TICKS = 40,
  parameter int ALARM_MAX   = 300,
  parameter int GAP_TICKS   = 1
) (
  input logic     clk,
  input logic     rst,
  piezo_if.slave  bus
);

  localparam int M1   = (KEY_TICKS > TIMER_TICKS) ? KEY_TICKS : TIMER_TICKS;
  localparam int M2   = (M1 > ALARM_MAX) ? M1 : ALARM_MAX;
  localparam int MAXD = (M2 > GAP_TICKS) ? M2 : GAP_TICKS;
  localparam int TW   = ($clog2(MAXD + 1) > 9) ? $clog2(MAXD + 1) : 9;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n, presc_step;
  logic [TW-1:0] tick_q, tick_n, tick_step;
  logic [TW-1:0] dur_q, dur_n, dur_sel;
  logic [2:0]    pend_q, pend_n, reqs, grant;
  logic [1:0]    src_q, src_n, hp;
  logic          done_q, done_n;
  logic          en_q, busy_q;
  logic          tick_end;

  assign reqs = {bus.alarm_req, bus.timer_req, bus.key_req};

  // src codes double as priority ranks: alarm 3 > timer 2 > key 1
  always_comb begin
    hp = 2'd0;
    if (pend_q[2])      hp = 2'd3;
    else if (pend_q[1]) hp = 2'd2;
    else if (pend_q[0]) hp = 2'd1;
  end

  assign grant = {hp == 2'd3, hp == 2'd2, hp == 2'd1};

  always_comb begin
    case (hp)
      2'd3:    dur_sel = TW'(ALARM_MAX);
      2'd2:    dur_sel = TW'(TIMER_TICKS);
      default: dur_sel = TW'(KEY_TICKS);
    endcase
  end

  assign tick_end   = (presc_q == P_LAST);
  assign presc_step = tick_end ? '0 : presc_q + 1'b1;
  assign tick_step  = tick_end ? tick_q + 1'b1 : tick_q;

  always_comb begin
    state_n = state_q;
    presc_n = presc_step;
    tick_n  = tick_step;
    dur_n   = dur_q;
    src_n   = src_q;
    pend_n  = pend_q | reqs;
    unique case (state_q)
      IDLE: begin
        presc_n = '0;
        tick_n  = '0;
        src_n   = 2'd0;
        if (hp != 2'd0) begin
          state_n = PLAY;
          src_n   = hp;
          dur_n   = dur_sel;
          pend_n  = (pend_q & ~grant) | reqs;
        end
      end
      PLAY: begin
        // done_q marks the last play cycle; expiry outranks preemption
        if (done_q || (hp > src_q)) begin
          state_n = GAP;
          presc_n = '0;
          tick_n  = '0;
          src_n   = 2'd0;
        end
      end
      GAP: begin
        if (tick_end && (tick_q == G_LAST)) begin
          state_n = IDLE;
          presc_n = '0;
          tick_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (bus.stop) begin
      state_n = IDLE;
      pend_n  = '0;
      src_n   = 2'd0;
      presc_n = '0;
      tick_n  = '0;
    end
    // registered done: flag the upcoming cycle as the final play cycle
    done_n = (state_n == PLAY) && (presc_n == P_LAST)
          && (tick_n == dur_n - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      src_q   <= 2'd0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      tick_q  <= tick_n;
      dur_q   <= dur_n;
      src_q   <= src_n;
      pend_q  <= pend_n;
      done_q  <= done_n;
      en_q    <= (state_n == PLAY);
      busy_q  <= (state_n != IDLE);
    end
  end

  assign bus.piezo_en = en_q;
  assign bus.src      = src_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pending  = pend_q;

endmodule

// File: tb/tb_piezo_sched.sv
// Directed and randomized check of piezo_sched against a countdown model.
// Model tracks mode, remaining cycles, source and pending bits per cycle.
module tb_piezo_sched;
  localparam int TD = 4;
  localparam int KT = 2;
  localparam int TT = 3;
  localparam int AT = 5;
  localparam int GT = 1;

  logic clk;
  logic rst;
  piezo_if bus ();

  piezo_sched #(
    .TICK_DIV(TD), .KEY_TICKS(KT), .TIMER_TICKS(TT),
    .ALARM_MAX(AT), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int done_cnt = 0;

  int       m_mode;
  int       m_left;
  int       m_src;
  bit [2:0] m_pend;
  int       durs [4] = '{0, KT, TT, AT};

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_src = 0; m_pend = 3'b000;
  endtask

  task automatic m_step(input bit k, t, a, s);
    int hp;
    hp = m_pend[2] ? 3 : m_pend[1] ? 2 : m_pend[0] ? 1 : 0;
    if (s) begin
      m_reset();
      return;
    end
    case (m_mode)
      0: if (hp != 0) begin
        m_pend[hp-1] = 1'b0;
        m_mode = 1; m_src = hp; m_left = durs[hp] * TD;
      end
      1: if (m_left == 1 || hp > m_src) begin
        m_mode = 2; m_left = GT * TD; m_src = 0;
      end else m_left--;
      default: if (m_left == 1) m_mode = 0; else m_left--;
    endcase
    m_pend |= {a, t, k};
  endtask

  task automatic cmp(input string tag, input int got, input int exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag);
    cmp({tag, ".en"}, int'(bus.piezo_en), int'(m_mode == 1));
    cmp({tag, ".src"}, int'(bus.src), (m_mode == 1) ? m_src : 0);
    cmp({tag, ".busy"}, int'(bus.busy), int'(m_mode != 0));
    cmp({tag, ".done"}, int'(bus.done), int'(m_mode == 1 && m_left == 1));
    cmp({tag, ".pend"}, int'(bus.pending), int'(m_pend));
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic step(input bit k, t, a, s, input string tag);
    bus.key_req = k; bus.timer_req = t; bus.alarm_req = a; bus.stop = s;
    @(posedge clk);
    m_step(k, t, a, s);
    @(negedge clk);
    bus.key_req = 0; bus.timer_req = 0; bus.alarm_req = 0; bus.stop = 0;
    chk(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, tag);
  endtask

  initial begin
    int en_cnt, done_at, idle_at, d0;
    rst = 1'b1;
    bus.key_req = 0; bus.timer_req = 0; bus.alarm_req = 0; bus.stop = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset");
    rst = 1'b0;

    // key beep: play cycles 2..9, done 9, idle from 14
    en_cnt = 0; done_at = -1; idle_at = -1;
    step(1, 0, 0, 0, "key");
    for (int c = 2; c <= 14; c++) begin
      step(0, 0, 0, 0, "key");
      if (bus.piezo_en === 1'b1) en_cnt++;
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
      if (bus.busy === 1'b0 && idle_at < 0) idle_at = c;
    end
    cmp("key.en_cycles", en_cnt, 8);
    cmp("key.done_at", done_at, 9);
    cmp("key.idle_at", idle_at, 14);

    // timer preempted by alarm
    d0 = done_cnt;
    step(0, 1, 0, 0, "preempt");
    run(4, "preempt");
    step(0, 0, 1, 0, "preempt");
    run(40, "preempt");
    cmp("preempt.dones", done_cnt - d0, 1);

    // all three at once: alarm, timer, key
    d0 = done_cnt;
    step(1, 1, 1, 0, "all3");
    run(60, "all3");
    cmp("all3.dones", done_cnt - d0, 3);

    // stop mid-play with timer pending
    d0 = done_cnt;
    step(0, 0, 1, 0, "stop");
    run(3, "stop");
    step(0, 1, 0, 0, "stop");
    run(2, "stop");
    cmp("stop.pend_before", int'(bus.pending), 2);
    step(0, 0, 0, 1, "stop");
    cmp("stop.pend", int'(bus.pending), 0);
    cmp("stop.busy", int'(bus.busy), 0);
    step(1, 0, 0, 1, "stop_key");
    cmp("stop_key.pend", int'(bus.pending), 0);
    run(3, "stop");
    cmp("stop.dones", done_cnt - d0, 0);

    // async reset mid-play
    step(1, 0, 0, 0, "arst");
    run(4, "arst");
    @(posedge clk);
    m_step(0, 0, 0, 0);
    #2 rst = 1'b1;
    m_reset();
    #1;
    cmp("arst.en", int'(bus.piezo_en), 0);
    cmp("arst.busy", int'(bus.busy), 0);
    chk("arst");
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    step(1, 0, 0, 0, "arst_key");
    run(15, "arst_key");
    cmp("arst_key.dones", done_cnt - d0, 1);

    // alarm pending on timer expiry cycle: expiry wins
    d0 = done_cnt;
    step(0, 1, 0, 0, "exp");
    run(11, "exp");
    step(0, 0, 1, 0, "exp");
    cmp("exp.done", int'(bus.done), 1);
    cmp("exp.pend", int'(bus.pending), 4);
    run(40, "exp");
    cmp("exp.dones", done_cnt - d0, 2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
